// File: rtl/riscv_ctrl_pkg.sv
// Shared control definitions for the multi-cycle sequencer: opcodes, state and
// class enums, ALU operation encodings.
package riscv_ctrl_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I_ALU  = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_FETCH     = 3'd1,
    ST_DECODE    = 3'd2,
    ST_EXECUTE   = 3'd3,
    ST_MEMORY    = 3'd4,
    ST_WRITEBACK = 3'd5,
    ST_FAULT     = 3'd6
  } state_t;

  typedef enum logic [3:0] {
    CLS_R      = 4'd0,
    CLS_I_ALU  = 4'd1,
    CLS_LOAD   = 4'd2,
    CLS_STORE  = 4'd3,
    CLS_BRANCH = 4'd4,
    CLS_JAL    = 4'd5,
    CLS_JALR   = 4'd6,
    CLS_LUI    = 4'd7,
    CLS_AUIPC  = 4'd8
  } cls_t;

  localparam logic [1:0] ALU_ADD    = 2'b00;
  localparam logic [1:0] ALU_BRANCH = 2'b01;
  localparam logic [1:0] ALU_R      = 2'b10;
  localparam logic [1:0] ALU_I      = 2'b11;

  function automatic logic [1:0] alu_ctrl_of(input cls_t cls);
    case (cls)
      CLS_R:      return ALU_R;
      CLS_I_ALU:  return ALU_I;
      CLS_BRANCH: return ALU_BRANCH;
      default:    return ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/opcode_classifier.sv
// Combinational decode of the 7-bit major opcode into an instruction class,
// flagging anything outside the supported set as illegal.
module opcode_classifier
  import riscv_ctrl_pkg::*;
(
  input  logic [6:0] opcode,
  output cls_t       cls,
  output logic       illegal
);

  always_comb begin
    cls     = CLS_R;
    illegal = 1'b0;
    case (opcode)
      OP_R:      cls = CLS_R;
      OP_I_ALU:  cls = CLS_I_ALU;
      OP_LOAD:   cls = CLS_LOAD;
      OP_STORE:  cls = CLS_STORE;
      OP_BRANCH: cls = CLS_BRANCH;
      OP_JAL:    cls = CLS_JAL;
      OP_JALR:   cls = CLS_JALR;
      OP_LUI:    cls = CLS_LUI;
      OP_AUIPC:  cls = CLS_AUIPC;
      default:   illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/multicycle_sequencer.sv
// Multi-cycle fetch/decode/execute/memory/writeback sequencer with bounded
// memory waits, a sticky fault state and a retired-instruction counter.
module multicycle_sequencer
  import riscv_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [6:0]  opcode,
  input  logic        imem_ready,
  input  logic        dmem_ready,
  output logic        imem_req,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic        ir_load,
  output logic        pc_write,
  output logic        branch_enable,
  output logic [1:0]  alu_control,
  output logic        imm_enable,
  output logic        mem_or_alu,
  output logic        reg_write_enable,
  output logic        retired,
  output logic [31:0] instret,
  output logic        fault,
  output logic [2:0]  state
);

  localparam int unsigned WAIT_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT_CYCLES - 1);

  state_t              state_q, state_d, next_st;
  cls_t                cls_q, cls_d, dec_cls;
  logic                dec_illegal;
  logic [WAIT_W-1:0]   wait_q, wait_d;
  logic [31:0]         instret_q, instret_d;

  opcode_classifier u_classifier (
    .opcode  (opcode),
    .cls     (dec_cls),
    .illegal (dec_illegal)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cls_q     <= CLS_R;
      wait_q    <= '0;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      cls_q     <= cls_d;
      wait_q    <= wait_d;
      instret_q <= instret_d;
    end
  end

  // wait_d defaults to zero, so any state change clears the counter on entry.
  always_comb begin
    state_d   = state_q;
    cls_d     = cls_q;
    wait_d    = '0;
    next_st   = start ? ST_FETCH : ST_IDLE;
    instret_d = retired ? instret_q + 32'd1 : instret_q;
    case (state_q)
      ST_IDLE:   if (start) state_d = ST_FETCH;
      ST_FETCH: begin
        if (imem_ready)              state_d = ST_DECODE;
        else if (wait_q == WAIT_LAST) state_d = ST_FAULT;
        else                          wait_d  = wait_q + 1'b1;
      end
      ST_DECODE: begin
        cls_d   = dec_cls;
        state_d = dec_illegal ? ST_FAULT : ST_EXECUTE;
      end
      ST_EXECUTE: begin
        case (cls_q)
          CLS_BRANCH:          state_d = next_st;
          CLS_LOAD, CLS_STORE: state_d = ST_MEMORY;
          default:             state_d = ST_WRITEBACK;
        endcase
      end
      ST_MEMORY: begin
        if (dmem_ready)               state_d = (cls_q == CLS_STORE) ? next_st : ST_WRITEBACK;
        else if (wait_q == WAIT_LAST) state_d = ST_FAULT;
        else                          wait_d  = wait_q + 1'b1;
      end
      ST_WRITEBACK: state_d = next_st;
      ST_FAULT:     state_d = ST_FAULT;
      default:      state_d = ST_FAULT;
    endcase
  end

  always_comb begin
    imem_req         = 1'b0;
    dmem_req         = 1'b0;
    dmem_we          = 1'b0;
    ir_load          = 1'b0;
    pc_write         = 1'b0;
    branch_enable    = 1'b0;
    alu_control      = ALU_ADD;
    imm_enable       = 1'b0;
    mem_or_alu       = 1'b0;
    reg_write_enable = 1'b0;
    retired          = 1'b0;
    fault            = 1'b0;
    if (state_q inside {ST_EXECUTE, ST_MEMORY, ST_WRITEBACK}) begin
      alu_control = alu_ctrl_of(cls_q);
      imm_enable  = !(cls_q inside {CLS_R, CLS_BRANCH});
    end
    case (state_q)
      ST_FETCH: begin
        imem_req = 1'b1;
        ir_load  = imem_ready;
      end
      ST_EXECUTE: begin
        if (cls_q == CLS_BRANCH) begin
          pc_write      = 1'b1;
          branch_enable = 1'b1;
          retired       = 1'b1;
        end
      end
      ST_MEMORY: begin
        dmem_req = 1'b1;
        dmem_we  = (cls_q == CLS_STORE);
        pc_write = (cls_q == CLS_STORE) && dmem_ready;
        retired  = (cls_q == CLS_STORE) && dmem_ready;
      end
      ST_WRITEBACK: begin
        reg_write_enable = 1'b1;
        pc_write         = 1'b1;
        retired          = 1'b1;
        mem_or_alu       = (cls_q == CLS_LOAD);
        branch_enable    = (cls_q inside {CLS_JAL, CLS_JALR});
      end
      ST_FAULT: fault = 1'b1;
      default: ;
    endcase
  end

  assign instret = instret_q;
  assign state   = state_q;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Scenario bench for multicycle_sequencer: per-cycle expected output vectors are
// queued as stimulus is driven and checked when the cycle's outputs are sampled.
module tb_multicycle_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [6:0]  opcode = 7'b0110011;
  logic        imem_ready = 1'b0;
  logic        dmem_ready = 1'b0;
  logic        imem_req, dmem_req, dmem_we, ir_load, pc_write, branch_enable;
  logic [1:0]  alu_control;
  logic        imm_enable, mem_or_alu, reg_write_enable, retired, fault;
  logic [31:0] instret;
  logic [2:0]  state;

  multicycle_sequencer #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .start(start), .opcode(opcode),
    .imem_ready(imem_ready), .dmem_ready(dmem_ready),
    .imem_req(imem_req), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .ir_load(ir_load), .pc_write(pc_write), .branch_enable(branch_enable),
    .alu_control(alu_control), .imm_enable(imm_enable), .mem_or_alu(mem_or_alu),
    .reg_write_enable(reg_write_enable), .retired(retired), .instret(instret),
    .fault(fault), .state(state)
  );

  always #5 clk = ~clk;

  // {state, imem_req, dmem_req, dmem_we, ir_load, pc_write, branch_enable,
  //  alu_control, imm_enable, mem_or_alu, reg_write_enable, retired, fault}
  logic [15:0] obs;
  assign obs = {state, imem_req, dmem_req, dmem_we, ir_load, pc_write, branch_enable,
                alu_control, imm_enable, mem_or_alu, reg_write_enable, retired, fault};

  localparam logic [15:0] IDLE_O     = 16'b000_000000_00_00000;
  localparam logic [15:0] FETCH_RDY  = 16'b001_100100_00_00000;
  localparam logic [15:0] FETCH_WAIT = 16'b001_100000_00_00000;
  localparam logic [15:0] DEC_O      = 16'b010_000000_00_00000;
  localparam logic [15:0] FAULT_O    = 16'b110_000000_00_00001;
  localparam logic [15:0] EX_R       = 16'b011_000000_10_00000;
  localparam logic [15:0] WB_R       = 16'b101_000010_10_00110;
  localparam logic [15:0] EX_LS      = 16'b011_000000_00_10000;
  localparam logic [15:0] MEM_LD     = 16'b100_010000_00_10000;
  localparam logic [15:0] WB_LD      = 16'b101_000010_00_11110;
  localparam logic [15:0] MEM_ST     = 16'b100_011010_00_10010;
  localparam logic [15:0] EX_BR      = 16'b011_000011_01_00010;

  localparam logic [6:0] R_OP  = 7'b0110011;
  localparam logic [6:0] LD_OP = 7'b0000011;
  localparam logic [6:0] ST_OP = 7'b0100011;
  localparam logic [6:0] BR_OP = 7'b1100011;
  localparam logic [6:0] BAD   = 7'b1111111;

  typedef struct {
    logic       s;
    logic       ir;
    logic       dr;
    logic [6:0] op;
    logic [15:0] e;
  } row_t;

  logic [15:0] sb[$];
  row_t        rows[$];
  logic [31:0] exp_instret = '0;
  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  function automatic row_t rw(input logic s, input logic ir, input logic dr,
                              input logic [6:0] op, input logic [15:0] e);
    row_t r;
    r.s = s; r.ir = ir; r.dr = dr; r.op = op; r.e = e;
    return r;
  endfunction

  // Inputs are applied just after the edge so they hold for the whole cycle,
  // including the transition taken at the following edge.
  task automatic drive_row(input row_t r);
    @(posedge clk);
    #1;
    start      = r.s;
    imem_ready = r.ir;
    dmem_ready = r.dr;
    opcode     = r.op;
    sb.push_back(r.e);
    @(negedge clk);
  endtask

  task automatic test_reset;
    logic [15:0] e;
    #3;
    n_cmp++;
    if (obs !== IDLE_O || instret !== 32'd0) begin
      n_err++;
      $display("FAIL reset_hold: outputs %b instret %0d, want %b instret 0", obs, instret, IDLE_O);
    end
    @(negedge clk);
    rst = 1'b0;
    rows.delete();
    rows.push_back(rw(1'b0, 1'b0, 1'b0, R_OP, IDLE_O));
    rows.push_back(rw(1'b0, 1'b1, 1'b1, R_OP, IDLE_O));
    foreach (rows[i]) begin
      drive_row(rows[i]);
      e = sb.pop_front();
      n_cmp++;
      if (obs !== e) begin
        n_err++;
        $display("FAIL reset_idle row %0d: got %b want %b", i, obs, e);
      end
    end
  endtask

  task automatic test_r_type;
    logic [15:0] e;
    rows.delete();
    rows.push_back(rw(1'b1, 1'b1, 1'b1, R_OP, IDLE_O));
    rows.push_back(rw(1'b1, 1'b1, 1'b1, R_OP, FETCH_RDY));
    rows.push_back(rw(1'b1, 1'b1, 1'b1, R_OP, DEC_O));
    rows.push_back(rw(1'b1, 1'b1, 1'b1, R_OP, EX_R));
    rows.push_back(rw(1'b1, 1'b1, 1'b1, R_OP, WB_R));
    rows.push_back(rw(1'b0, 1'b1, 1'b1, R_OP, FETCH_RDY));
    rows.push_back(rw(1'b0, 1'b1, 1'b1, R_OP, DEC_O));
    rows.push_back(rw(1'b0, 1'b1, 1'b1, R_OP, EX_R));
    rows.push_back(rw(1'b0, 1'b1, 1'b1, R_OP, WB_R));
    rows.push_back(rw(1'b0, 1'b1, 1'b1, R_OP, IDLE_O));
    foreach (rows[i]) begin
      drive_row(rows[i]);
      e = sb.pop_front();
      n_cmp++;
      if (obs !== e) begin
        n_err++;
        $display("FAIL r_type row %0d: got %b want %b", i, obs, e);
      end
      n_cmp++;
      if (instret !== exp_instret) begin
        n_err++;
        $display("FAIL r_type_instret row %0d: got %0d want %0d", i, instret, exp_instret);
      end
      if (e[1]) exp_instret = exp_instret + 32'd1;
    end
  endtask

  task automatic test_async_reset;
    @(posedge clk); #1;
    start = 1'b1; imem_ready = 1'b0;
    @(posedge clk); #1;
    n_cmp++;
    if (obs !== FETCH_WAIT) begin
      n_err++;
      $display("FAIL pre_reset_fetch: got %b want %b", obs, FETCH_WAIT);
    end
    #1 rst = 1'b1;
    #1;
    n_cmp++;
    if (obs !== IDLE_O || instret !== 32'd0) begin
      n_err++;
      $display("FAIL async_reset: outputs %b instret %0d, want %b instret 0", obs, instret, IDLE_O);
    end
    start = 1'b0;
    #1 rst = 1'b0;
    exp_instret = '0;
  endtask

  task automatic test_load;
    logic [15:0] e;
    rows.delete();
    rows.push_back(rw(1'b1, 1'b1, 1'b0, LD_OP, IDLE_O));
    rows.push_back(rw(1'b0, 1'b1, 1'b0, LD_OP, FETCH_RDY));
    rows.push_back(rw(1'b0, 1'b1, 1'b0, LD_OP, DEC_O));
    rows.push_back(rw(1'b0, 1'b1, 1'b0, LD_OP, EX_LS));
    rows.push_back(rw(1'b0, 1'b1, 1'b0, LD_OP, MEM_LD));
    rows.push_back(rw(1'b0, 1'b1, 1'b0, LD_OP, MEM_LD));
    rows.push_back(rw(1'b0, 1'b1, 1'b0, LD_OP, MEM_LD));
    rows.push_back(rw(1'b0, 1'b1, 1'b1, LD_OP, MEM_LD));
    rows.push_back(rw(1'b0, 1'b1, 1'b0, LD_OP, WB_LD));
    rows.push_back(rw(1'b0, 1'b1, 1'b0, LD_OP, IDLE_O));
    foreach (rows[i]) begin
      drive_row(rows[i]);
      e = sb.pop_front();
      n_cmp++;
      if (obs !== e) begin
        n_err++;
        $display("FAIL load row %0d: got %b want %b", i, obs, e);
      end
      n_cmp++;
      if (instret !== exp_instret) begin
        n_err++;
        $display("FAIL load_instret row %0d: got %0d want %0d", i, instret, exp_instret);
      end
      if (e[1]) exp_instret = exp_instret + 32'd1;
    end
  endtask

  task automatic test_store_branch;
    logic [15:0] e;
    rows.delete();
    rows.push_back(rw(1'b1, 1'b1, 1'b1, ST_OP, IDLE_O));
    rows.push_back(rw(1'b1, 1'b1, 1'b1, ST_OP, FETCH_RDY));
    rows.push_back(rw(1'b1, 1'b1, 1'b1, ST_OP, DEC_O));
    rows.push_back(rw(1'b1, 1'b1, 1'b1, ST_OP, EX_LS));
    rows.push_back(rw(1'b1, 1'b1, 1'b1, ST_OP, MEM_ST));
    rows.push_back(rw(1'b1, 1'b1, 1'b1, BR_OP, FETCH_RDY));
    rows.push_back(rw(1'b1, 1'b1, 1'b1, BR_OP, DEC_O));
    rows.push_back(rw(1'b0, 1'b1, 1'b1, BR_OP, EX_BR));
    rows.push_back(rw(1'b0, 1'b1, 1'b1, BR_OP, IDLE_O));
    foreach (rows[i]) begin
      drive_row(rows[i]);
      e = sb.pop_front();
      n_cmp++;
      if (obs !== e) begin
        n_err++;
        $display("FAIL store_branch row %0d: got %b want %b", i, obs, e);
      end
      n_cmp++;
      if (instret !== exp_instret) begin
        n_err++;
        $display("FAIL store_branch_instret row %0d: got %0d want %0d", i, instret, exp_instret);
      end
      if (e[1]) exp_instret = exp_instret + 32'd1;
    end
  endtask

  task automatic test_illegal;
    logic [15:0] e;
    rows.delete();
    rows.push_back(rw(1'b1, 1'b1, 1'b0, BAD, IDLE_O));
    rows.push_back(rw(1'b1, 1'b1, 1'b0, BAD, FETCH_RDY));
    rows.push_back(rw(1'b1, 1'b1, 1'b0, BAD, DEC_O));
    rows.push_back(rw(1'b1, 1'b1, 1'b0, BAD, FAULT_O));
    rows.push_back(rw(1'b0, 1'b1, 1'b0, BAD, FAULT_O));
    rows.push_back(rw(1'b1, 1'b1, 1'b1, R_OP, FAULT_O));
    rows.push_back(rw(1'b0, 1'b1, 1'b1, R_OP, FAULT_O));
    foreach (rows[i]) begin
      drive_row(rows[i]);
      e = sb.pop_front();
      n_cmp++;
      if (obs !== e) begin
        n_err++;
        $display("FAIL illegal row %0d: got %b want %b", i, obs, e);
      end
    end
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if (obs !== IDLE_O) begin
      n_err++;
      $display("FAIL illegal_clear: got %b want %b", obs, IDLE_O);
    end
    #1 rst = 1'b0;
    exp_instret = '0;
  endtask

  task automatic test_timeout;
    logic [15:0] e;
    rows.delete();
    rows.push_back(rw(1'b1, 1'b0, 1'b0, R_OP, IDLE_O));
    for (int k = 0; k < 4; k++) rows.push_back(rw(1'b1, 1'b0, 1'b0, R_OP, FETCH_WAIT));
    rows.push_back(rw(1'b0, 1'b0, 1'b0, R_OP, FAULT_O));
    foreach (rows[i]) begin
      drive_row(rows[i]);
      e = sb.pop_front();
      n_cmp++;
      if (obs !== e) begin
        n_err++;
        $display("FAIL timeout row %0d: got %b want %b", i, obs, e);
      end
    end
    #2 rst = 1'b1;
    #2 rst = 1'b0;
    rows.delete();
    rows.push_back(rw(1'b1, 1'b0, 1'b0, R_OP, IDLE_O));
    for (int k = 0; k < 3; k++) rows.push_back(rw(1'b1, 1'b0, 1'b0, R_OP, FETCH_WAIT));
    rows.push_back(rw(1'b0, 1'b1, 1'b0, R_OP, FETCH_RDY));
    rows.push_back(rw(1'b0, 1'b1, 1'b0, R_OP, DEC_O));
    rows.push_back(rw(1'b0, 1'b1, 1'b0, R_OP, EX_R));
    rows.push_back(rw(1'b0, 1'b1, 1'b0, R_OP, WB_R));
    rows.push_back(rw(1'b0, 1'b1, 1'b0, R_OP, IDLE_O));
    foreach (rows[i]) begin
      drive_row(rows[i]);
      e = sb.pop_front();
      n_cmp++;
      if (obs !== e) begin
        n_err++;
        $display("FAIL timeout_edge row %0d: got %b want %b", i, obs, e);
      end
    end
    exp_instret = 32'd1;
  endtask

  task automatic test_wrap;
    logic [15:0] e;
    @(negedge clk);
    force dut.instret_q = 32'hFFFF_FFFF;
    #1 release dut.instret_q;
    exp_instret = 32'hFFFF_FFFF;
    rows.delete();
    rows.push_back(rw(1'b1, 1'b1, 1'b1, R_OP, IDLE_O));
    rows.push_back(rw(1'b0, 1'b1, 1'b1, R_OP, FETCH_RDY));
    rows.push_back(rw(1'b0, 1'b1, 1'b1, R_OP, DEC_O));
    rows.push_back(rw(1'b0, 1'b1, 1'b1, R_OP, EX_R));
    rows.push_back(rw(1'b0, 1'b1, 1'b1, R_OP, WB_R));
    rows.push_back(rw(1'b0, 1'b1, 1'b1, R_OP, IDLE_O));
    foreach (rows[i]) begin
      drive_row(rows[i]);
      e = sb.pop_front();
      n_cmp++;
      if (obs !== e) begin
        n_err++;
        $display("FAIL wrap row %0d: got %b want %b", i, obs, e);
      end
      n_cmp++;
      if (instret !== exp_instret) begin
        n_err++;
        $display("FAIL wrap_instret row %0d: got %h want %h", i, instret, exp_instret);
      end
      if (e[1]) exp_instret = exp_instret + 32'd1;
    end
    n_cmp++;
    if (instret !== 32'd0) begin
      n_err++;
      $display("FAIL wrap_final: got %h want 00000000", instret);
    end
  endtask

  initial begin
    test_reset();
    test_r_type();
    test_async_reset();
    test_load();
    test_store_branch();
    test_illegal();
    test_timeout();
    test_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/multicycle_sequencer.md
# multicycle_sequencer

Multi-cycle instruction sequencer for the RISC-V core. It steps each instruction through fetch, decode, execute, memory and writeback states, and drives the datapath enables from a registered opcode class. It handles variable-latency instruction and data memory handshakes and counts retired instructions. Illegal opcodes and memory timeouts drive it into a sticky fault state. It sits between the instruction register, the memories, the register file and the ALU.

## Interface
- `TIMEOUT_CYCLES`, default 64: maximum number of cycles spent waiting for `imem_ready` or `dmem_ready` before faulting. Must be at least 2.
- `clk` in 1: the single clock; all state changes on the rising edge.
- `rst` in 1: reset, asynchronous and active-high.
- `start` in 1: run enable, level-sensitive.
- `opcode` in 7: `instr[6:0]` taken from the instruction register.
- `imem_ready` in 1: the instruction word is valid this cycle.
- `dmem_ready` in 1: the data access completes this cycle.
- `imem_req` out 1: instruction fetch request.
- `dmem_req` out 1: data access request.
- `dmem_we` out 1: data write, meaning a store.
- `ir_load` out 1: capture the instruction word into the instruction register.
- `pc_write` out 1: update the PC.
- `branch_enable` out 1: select the branch/jump target for the PC update.
- `alu_control` out 2: ALU operation class.
- `imm_enable` out 1: ALU operand B is the immediate.
- `mem_or_alu` out 1: writeback source; 1 selects memory.
- `reg_write_enable` out 1: register file write.
- `retired` out 1: one-cycle pulse for each completed instruction.
- `instret` out 32: count of retired instructions.
- `fault` out 1: sticky error flag.
- `state` out 3: current state, for debug.

## Operation
- States and their encoding: IDLE=0, FETCH=1, DECODE=2, EXECUTE=3, MEMORY=4, WRITEBACK=5, FAULT=6.
- **IDLE**: if `start`=1, go to FETCH.
- **FETCH**: assert `imem_req`.
  - On `imem_ready`: pulse `ir_load` in that same cycle, then go to DECODE.
- **DECODE**: classify `opcode` and register the class into `cls_q`.
  - Classes: R, I_ALU, LOAD, STORE, BRANCH, JAL, JALR, LUI, AUIPC.
  - Any other opcode goes to FAULT.
  - Otherwise go to EXECUTE.
- **EXECUTE**:
  - BRANCH: assert `pc_write`, `branch_enable` and `retired`, then go to NEXT.
  - LOAD and STORE: go to MEMORY.
  - All other classes: go to WRITEBACK.
- **MEMORY**: assert `dmem_req`; assert `dmem_we` for STORE only.
  - On `dmem_ready`, STORE: assert `pc_write` and `retired`, then go to NEXT.
  - On `dmem_ready`, LOAD: go to WRITEBACK.
- **WRITEBACK**: assert `reg_write_enable`, `pc_write` and `retired`, then go to NEXT.
  - `mem_or_alu`=1 for LOAD only.
  - `branch_enable`=1 for JAL and JALR.
- **NEXT** is the follow-on state after a retire: FETCH if `start`=1, otherwise IDLE. Dropping `start` mid-instruction lets that instruction complete.
- `alu_control` and `imm_enable` are driven from `cls_q` in EXECUTE, MEMORY and WRITEBACK, and are 0 in all other states.
  - `alu_control`: R=10, I_ALU=11, BRANCH=01, all others 00.
  - `imm_enable`=1 for every class except R and BRANCH.
- **Wait counter**:
  - Cleared on entry to FETCH or MEMORY.
  - Increments each cycle that state is held without the matching ready.
  - If the counter equals `TIMEOUT_CYCLES-1` and ready is still low, go to FAULT.
  - Ready arriving on that same cycle wins over the timeout.
- **FAULT**: `fault`=1, all other enables 0, `start` ignored. Only `rst` exits.
- `instret` increments on every `retired` pulse and wraps from 0xFFFFFFFF to 0.

## Timing
- Outputs are decoded from registered state and `cls_q` only. `ir_load`, `pc_write` and `retired` also depend on the ready inputs.
- **Reset**: asynchronous `rst` immediately forces the following, with no wait for a clock edge:
  - state = IDLE;
  - `cls_q`, wait counter, `instret` and `fault` cleared to 0;
  - every output 0, so requests drop at once.
- Minimum instruction latency with ready tied high:
  - BRANCH: 3 cycles.
  - R, I_ALU, JAL, JALR, LUI, AUIPC, STORE: 4 cycles.
  - LOAD: 5 cycles.
- Each cycle of memory wait adds one cycle of latency.
- `retired` is high for exactly one cycle per instruction. `instret` shows the new value on the following cycle.
- `opcode` is sampled only in DECODE. The instruction register changes only on `ir_load`.

## Structure
- Shared package `riscv_ctrl_pkg` holds:
  - the opcode constants for R, I_ALU, LOAD, STORE, BRANCH, JAL, JALR, LUI and AUIPC;
  - the state enum;
  - the class enum;
  - the `alu_control` encodings 00/01/10/11.
- Sub-module `opcode_classifier`: combinational mapping from `opcode` to class plus an `illegal` flag, instantiated once.
- The state register, wait counter, `cls_q` and `instret` live in the top module.

## Test plan
- **Reset**: pulse `rst` between clock edges → all outputs 0, `state`=0, `instret`=0 before the next edge.
- **R-type**: `opcode`=0110011, both ready inputs tied 1, `start`=1.
  - Cycles 1–4: FETCH→DECODE→EXECUTE→WRITEBACK.
  - `ir_load` in cycle 1, `alu_control`=10 in cycle 3, `reg_write_enable`+`retired` in cycle 4.
  - `instret`=1 after that; FETCH again in cycle 5.
- **Load**: `opcode`=0000011 with `dmem_ready` low for 3 cycles.
  - `dmem_req` held for 4 cycles, `dmem_we`=0.
  - WRITEBACK has `mem_or_alu`=1; 8 cycles in total.
- **Store then branch**:
  - Store `opcode`=0100011: `dmem_we`=1 with `dmem_req`, `reg_write_enable` never asserted, retires in MEMORY.
  - Branch `opcode`=1100011: `pc_write`+`branch_enable` in EXECUTE, `alu_control`=01.
- **Illegal opcode**: `opcode`=1111111 → FAULT after DECODE, `fault`=1.
  - `fault` stays 1 while `start` toggles; `rst` clears it.
- **Timeout**: `TIMEOUT_CYCLES`=4, `imem_ready`=0 → FAULT after the 4th FETCH cycle.
  - Rerun with `imem_ready`=1 on the 4th cycle → DECODE, no fault.
- **Wrap**: preload `instret` to 0xFFFFFFFF via force, retire one instruction → `instret`=0.
